axi_traffic_gen: RTL and testbench
==================================

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 1: width of all ID fields.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32: data width; legal values are 32, 64 and 128.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles allowed per wait phase.
REQ-005 SHALL have port ACLK, input, 1: the single clock.
REQ-006 SHALL have port ARESETN, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port START, input, 1: one-cycle request to run one write-then-read pass.
REQ-008 SHALL have port BASE_ADDR, input, AXI_ADDR_WIDTH: byte address of the burst, aligned to the bus width.
REQ-009 SHALL have port BURST_LEN, input, 8: number of beats minus 1 (AXI encoding).
REQ-010 SHALL have port SEED, input, AXI_DATA_WIDTH: seed for the data pattern.
REQ-011 SHALL have port BUSY, output, 1: high while a pass is in progress.
REQ-012 SHALL have port DONE, output, 1: one-cycle pulse when a pass ends.
REQ-013 SHALL have port ERROR, output, 1: sticky error flag.
REQ-014 SHALL have port MISMATCH_CNT, output, 9: number of read beats whose data did not match.
REQ-015 SHALL have the M_AXI_AW* ports (AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out; AWREADY in), forming the AXI4 write-address master.
REQ-016 SHALL have the M_AXI_W* ports (WDATA, WSTRB, WLAST, WVALID out; WREADY in) and M_AXI_B* ports (BID, BRESP, BVALID in; BREADY out).
REQ-017 SHALL have the M_AXI_AR* ports (same set as AW) and M_AXI_R* ports (RID, RDATA, RRESP, RLAST, RVALID in; RREADY out).

Function
REQ-018 SHALL implement the state machine IDLE->AW->W->B->AR->R->FIN->IDLE.
REQ-019 SHALL act on START only in IDLE, latching BASE_ADDR, BURST_LEN and SEED; START while BUSY SHALL be ignored.
REQ-020 SHALL clear ERROR and MISMATCH_CNT when START is accepted.
REQ-021 SHALL generate beat k's data as SEED + k, zero-extended index, modulo 2^AXI_DATA_WIDTH.
REQ-022 SHALL drive constant fields: AWBURST/ARBURST=INCR; AWSIZE/ARSIZE=log2(AXI_DATA_WIDTH/8); IDs=0; WSTRB=all ones.
REQ-023 SHALL hold VALID and its payload stable from assertion until the READY handshake on every channel.
REQ-024 SHALL assert AWVALID one cycle after START is accepted.
REQ-025 SHALL enter W the cycle after the AW handshake.
REQ-026 SHALL issue beats back-to-back in W while WREADY stays high, with WLAST high only on beat BURST_LEN; BURST_LEN=0 SHALL give one beat with WLAST set.
REQ-027 SHALL hold BREADY high throughout B; a BRESP other than OKAY SHALL set ERROR, and the pass SHALL continue.
REQ-028 SHALL hold RREADY high throughout R, count beats, and leave R on the RLAST handshake.
REQ-029 SHALL set ERROR if RLAST arrives at a beat count other than BURST_LEN+1, or if RRESP is not OKAY.
REQ-030 SHALL count cycles in each of AW, W, B, AR and R and reset the count on every handshake; reaching TIMEOUT SHALL set ERROR, drop all VALID/READY outputs and go to FIN.
REQ-031 SHALL stay in FIN for exactly one cycle, pulse DONE and deassert BUSY.
REQ-032 SHALL NOT check 4 KB boundary crossing; keeping bursts within 4 KB is the caller's responsibility.

Reset
REQ-033 SHALL, while ARESETN is low: set state IDLE; all VALID/READY outputs, BUSY, DONE and ERROR 0; MISMATCH_CNT 0; AXI payload outputs 0.
REQ-034 SHALL abandon a pass immediately if reset is asserted mid-pass, with no DONE pulse.

Configuration
REQ-035 SHALL, with macro AXI_TG_CHECK_EN defined, compare each RDATA against SEED+k, increment MISMATCH_CNT (saturating at 511) and set ERROR on any mismatch.
REQ-036 SHALL, without AXI_TG_CHECK_EN, discard RDATA, tie MISMATCH_CNT to 0, and keep only the RRESP and RLAST checks.

Structure
REQ-037 SHALL take the state encoding, BURST_* and RESP_* constants from shared package axi_pkg.
REQ-038 SHALL place the pattern generator (SEED+k, stepping on a beat enable, with a restart input) in sub-module axi_tg_pattern, instantiated once for W and once for R.

Verification
REQ-039 Scenario: BASE_ADDR=0x40, BURST_LEN=31, SEED=0x64343962, memory slave -> 32 W beats, WLAST on beat 31, BRESP OKAY, 32 R beats, DONE pulse, ERROR=0, MISMATCH_CNT=0.
REQ-040 Scenario: BURST_LEN=0 -> a single beat with WLAST=1, then a single R beat with RLAST=1, then DONE.
REQ-041 Scenario: slave corrupts R beat 5 (CHECK_EN on) -> MISMATCH_CNT=1 and ERROR=1; with CHECK_EN off -> MISMATCH_CNT=0 and ERROR=0.
REQ-042 Scenario: AWREADY held low, TIMEOUT=16 -> AWVALID drops after 16 cycles, then ERROR=1 and DONE pulse.
REQ-043 Scenario: random WREADY/RVALID stalls -> WDATA stable while stalled, and the pass completes with correct data.
REQ-044 Scenario: ARESETN low during W, and START pulsed while BUSY -> all outputs return to 0 on reset; the START pulse is ignored.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: traffic generator FSM encoding plus the AXI burst/response
// constants and the AxSIZE helper shared by the generator files.
package axi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FIN} tg_state_e;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  function automatic logic [2:0] axi_size(input int dw);
    return dw == 128 ? 3'd4 : dw == 64 ? 3'd3 : 3'd2;
  endfunction
endpackage

// File: rtl/axi_tg_pattern.sv
// axi_tg_pattern: beat data generator producing SEED+k; restart loads the seed,
// step advances to the next beat.
module axi_tg_pattern #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          step,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] data
);
  logic [DW-1:0] data_q, data_d;
  always_comb data_d = restart ? seed : step ? data_q + DW'(1) : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  assign data = data_q;
endmodule

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: AXI4 master running one write-then-read INCR burst per START.
// Define AXI_TG_CHECK_EN to compare read data against the pattern and count mismatches.
module axi_traffic_gen
  import axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT        = 1024
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        START,
  input  logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR,
  input  logic [7:0]                  BURST_LEN,
  input  logic [AXI_DATA_WIDTH-1:0]   SEED,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR,
  output logic [8:0]                  MISMATCH_CNT,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                  M_AXI_AWLEN,
  output logic [2:0]                  M_AXI_AWSIZE,
  output logic [1:0]                  M_AXI_AWBURST,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WLAST,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] SIZE = axi_size(AXI_DATA_WIDTH);
  tg_state_e state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, wcnt_q, wcnt_d;
  logic [8:0] rcnt_q, rcnt_d, mis_q, mis_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] wpat, rpat;
  logic start, aw_hs, w_hs, b_hs, ar_hs, r_hs, hs, waiting, expired, rbad, unused_ok;
  assign M_AXI_AWVALID = state_q == S_AW;
  assign M_AXI_WVALID  = state_q == S_W;
  assign M_AXI_BREADY  = state_q == S_B;
  assign M_AXI_ARVALID = state_q == S_AR;
  assign M_AXI_RREADY  = state_q == S_R;
  assign start   = state_q == S_IDLE && START;
  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs    = M_AXI_BREADY && M_AXI_BVALID;
  assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs    = M_AXI_RREADY && M_AXI_RVALID;
  assign hs      = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign waiting = M_AXI_AWVALID | M_AXI_WVALID | M_AXI_BREADY | M_AXI_ARVALID | M_AXI_RREADY;
  assign expired = waiting && !hs && tmo_q == TW'(TIMEOUT - 1);
  axi_tg_pattern #(.DW(AXI_DATA_WIDTH)) u_wpat (
    .clk(ACLK), .rst_n(ARESETN), .restart(start), .step(w_hs), .seed(SEED), .data(wpat)
  );
  axi_tg_pattern #(.DW(AXI_DATA_WIDTH)) u_rpat (
    .clk(ACLK), .rst_n(ARESETN), .restart(start), .step(r_hs), .seed(SEED), .data(rpat)
  );
`ifdef AXI_TG_CHECK_EN
  assign rbad = M_AXI_RDATA != rpat;
  assign MISMATCH_CNT = mis_q;
  assign unused_ok = ^{M_AXI_BID, M_AXI_RID};
`else
  assign rbad = 1'b0;
  assign MISMATCH_CNT = '0;
  assign unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_RDATA, rpat, mis_q};
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    mis_d   = mis_q;
    err_d   = err_q;
    tmo_d   = waiting && !hs ? tmo_q + TW'(1) : '0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_AW;
        addr_d  = BASE_ADDR;
        len_d   = BURST_LEN;
        wcnt_d  = '0;
        rcnt_d  = '0;
        mis_d   = '0;
        err_d   = 1'b0;
      end
      S_AW: if (aw_hs) state_d = S_W;
      S_W: if (w_hs) begin
        wcnt_d  = wcnt_q + 8'd1;
        state_d = M_AXI_WLAST ? S_B : S_W;
      end
      S_B: if (b_hs) begin
        state_d = S_AR;
        err_d   = err_q | (M_AXI_BRESP != RESP_OKAY);
      end
      S_AR: if (ar_hs) state_d = S_R;
      S_R: if (r_hs) begin
        rcnt_d  = rcnt_q + 9'd1;
        mis_d   = rbad && mis_q != 9'h1FF ? mis_q + 9'd1 : mis_q;
        err_d   = err_q | rbad | (M_AXI_RRESP != RESP_OKAY) | (M_AXI_RLAST && rcnt_q != {1'b0, len_q});
        state_d = M_AXI_RLAST ? S_FIN : S_R;
      end
      default: state_d = S_IDLE;
    endcase
    if (expired) begin
      state_d = S_FIN;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      mis_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  // Constant payload fields read as zero whenever their channel is idle.
  assign BUSY          = waiting;
  assign DONE          = state_q == S_FIN;
  assign ERROR         = err_q;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = M_AXI_AWVALID ? SIZE : 3'd0;
  assign M_AXI_AWBURST = M_AXI_AWVALID ? BURST_INCR : 2'd0;
  assign M_AXI_WDATA   = wpat;
  assign M_AXI_WSTRB   = {(AXI_DATA_WIDTH/8){M_AXI_WVALID}};
  assign M_AXI_WLAST   = M_AXI_WVALID && wcnt_q == len_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = M_AXI_ARVALID ? SIZE : 3'd0;
  assign M_AXI_ARBURST = M_AXI_ARVALID ? BURST_INCR : 2'd0;
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: memory-slave bench with a pass-level reference model,
// table vectors, randomized passes and reset/timeout sequences.
module tb_axi_traffic_gen;
`ifdef AXI_TG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic ACLK, ARESETN, START, BUSY, DONE, ERROR;
  logic [31:0] BASE_ADDR, SEED;
  logic [7:0] BURST_LEN;
  logic [8:0] MISMATCH_CNT;
  logic [0:0] AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_traffic_gen #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .BASE_ADDR(BASE_ADDR), .BURST_LEN(BURST_LEN),
    .SEED(SEED), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .MISMATCH_CNT(MISMATCH_CNT),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY), .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY), .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
    .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID),
    .M_AXI_ARREADY(ARREADY), .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
    .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] base; int len; logic [31:0] seed; bit stall;
    int corrupt; bit corrupt_all; logic [1:0] bresp; int rerr; int rlast_at;
    bit aw_block; bit poke; bit exp_err; int exp_mis;
  } vec_t;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // slave configuration and the pass currently expected by the model
  bit cfg_stall, cfg_aw_block, cfg_corrupt_all;
  int cfg_corrupt, cfg_rerr, cfg_rlast_at;
  logic [1:0] cfg_bresp;
  logic [31:0] cur_base, cur_seed;
  int cur_len;
  int w_cnt, r_cnt, aw_cnt, awv_cycles;
  logic [31:0] mem [0:1023];

  function automatic bit coin();
    return !cfg_stall || ($urandom % 4 != 0);
  endfunction

  // Memory slave: readies/valids are chosen at the falling edge, so the
  // handshake computed here is exactly what the next rising edge samples.
  initial begin
    int wbase, wbeat, rbase, rbeat, rlen;
    bit b_pend, b_take, r_act, r_take, w_stalled;
    logic [31:0] wdata_prev;
    {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} = '0;
    {BID, RID, BRESP, RRESP, RDATA} = '0;
    {b_pend, b_take, r_act, r_take, w_stalled} = '0;
    {wbase, wbeat, rbase, rbeat, rlen} = '0;
    wdata_prev = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} = '0;
        {b_pend, b_take, r_act, r_take, w_stalled} = '0;
      end else begin
        if (AWVALID) awv_cycles++;
        if (w_stalled) chk("w_stable", {WVALID, WDATA}, {1'b1, wdata_prev});
        if (b_take) begin BVALID = 1'b0; b_take = 1'b0; end
        if (b_pend && !BVALID) begin BVALID = 1'b1; BRESP = cfg_bresp; b_pend = 1'b0; end
        if (BVALID && BREADY) b_take = 1'b1;
        if (r_take) begin RVALID = 1'b0; RLAST = 1'b0; r_take = 1'b0; end
        if (r_act && !RVALID && coin()) begin
          RVALID = 1'b1;
          RDATA  = mem[(rbase + rbeat) % 1024] ^ ((cfg_corrupt_all || rbeat == cfg_corrupt) ? 32'h1 : 32'h0);
          RLAST  = rbeat == (cfg_rlast_at >= 0 ? cfg_rlast_at : rlen);
          RRESP  = rbeat == cfg_rerr ? 2'd2 : 2'd0;
        end
        if (RVALID && RREADY) begin
          r_take = 1'b1; r_cnt++; rbeat++;
          if (RLAST) r_act = 1'b0;
        end
        AWREADY = !cfg_aw_block && coin();
        if (AWVALID && AWREADY) begin
          aw_cnt++;
          chk("aw_fields", {AWADDR, AWLEN, AWSIZE, AWBURST, AWID}, {cur_base, 8'(cur_len), 3'd2, 2'd1, 1'b0});
          wbase = int'(AWADDR >> 2); wbeat = 0;
        end
        WREADY = coin();
        w_stalled = WVALID && !WREADY;
        wdata_prev = WDATA;
        if (WVALID && WREADY) begin
          chk("w_beat", {WDATA, WLAST, WSTRB}, {cur_seed + 32'(wbeat), wbeat == cur_len, 4'hF});
          mem[(wbase + wbeat) % 1024] = WDATA;
          wbeat++; w_cnt++;
          if (WLAST) b_pend = 1'b1;
        end
        ARREADY = coin();
        if (ARVALID && ARREADY) begin
          chk("ar_fields", {ARADDR, ARLEN, ARSIZE, ARBURST, ARID}, {cur_base, 8'(cur_len), 3'd2, 2'd1, 1'b0});
          rbase = int'(ARADDR >> 2); rbeat = 0; rlen = cur_len; r_act = 1'b1;
        end
      end
    end
  end

  function automatic vec_t mk(logic [31:0] base, int len, logic [31:0] seed, bit stall, int corrupt,
                              bit call, logic [1:0] bresp, int rerr, int rlast, bit blk, bit poke,
                              bit err, int mis);
    vec_t v;
    v.base = base; v.len = len; v.seed = seed; v.stall = stall; v.corrupt = corrupt;
    v.corrupt_all = call; v.bresp = bresp; v.rerr = rerr; v.rlast_at = rlast;
    v.aw_block = blk; v.poke = poke; v.exp_err = err; v.exp_mis = mis;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, BUSY, DONE, ERROR}, '0);
    chk({tag, "_mis"}, MISMATCH_CNT, '0);
    chk({tag, "_payload"}, {AWADDR, WDATA}, '0);
    chk({tag, "_fields"}, {ARADDR, AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, WSTRB}, '0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit done;
    cfg_stall = v.stall; cfg_aw_block = v.aw_block; cfg_corrupt = v.corrupt;
    cfg_corrupt_all = v.corrupt_all; cfg_bresp = v.bresp; cfg_rerr = v.rerr; cfg_rlast_at = v.rlast_at;
    cur_base = v.base; cur_seed = v.seed; cur_len = v.len;
    w_cnt = 0; r_cnt = 0; aw_cnt = 0; awv_cycles = 0;
    @(negedge ACLK);
    START = 1'b1; BASE_ADDR = v.base; BURST_LEN = 8'(v.len); SEED = v.seed;
    @(negedge ACLK);
    START = 1'b0;
    chk({name, "_start"}, {AWVALID, BUSY, ERROR, MISMATCH_CNT}, {1'b1, 1'b1, 1'b0, 9'd0});
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (DONE) begin done = 1'b1; break; end
      START = v.poke && i == 2;
      if (START) BASE_ADDR = 32'h3F0;
      @(negedge ACLK);
    end
    START = 1'b0;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_err_mis"}, {ERROR, MISMATCH_CNT}, {v.exp_err, 9'(v.exp_mis)});
    chk({name, "_beats"}, {32'(w_cnt), 32'(r_cnt)},
        v.aw_block ? 64'd0 : {32'(v.len + 1), 32'(v.rlast_at >= 0 ? v.rlast_at + 1 : v.len + 1)});
    chk({name, "_aw_count"}, aw_cnt, v.aw_block ? 0 : 1);
    if (v.aw_block) chk({name, "_awvalid_cycles"}, awv_cycles, 16);
    @(negedge ACLK);
    chk({name, "_fin_one_cycle"}, {DONE, BUSY}, 2'b00);
  endtask

  initial begin
    vec_t tbl [10];
    vec_t v;
    int mode;
    bit seen;
    ARESETN = 1'b0; START = 1'b0; BASE_ADDR = '0; BURST_LEN = '0; SEED = '0;
    cfg_stall = 0; cfg_aw_block = 0; cfg_corrupt = -1; cfg_corrupt_all = 0;
    cfg_bresp = 0; cfg_rerr = -1; cfg_rlast_at = -1;
    cur_base = 0; cur_seed = 0; cur_len = 0;
    w_cnt = 0; r_cnt = 0; aw_cnt = 0; awv_cycles = 0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    //            base      len  seed          st cor all br rerr rlast blk poke err mis
    tbl[0] = mk(32'h40,   31, 32'h64343962, 0, -1, 0, 0, -1, -1, 0, 0, 0, 0);
    tbl[1] = mk(32'h100,   0, 32'hFFFFFFFF, 0, -1, 0, 0, -1, -1, 0, 0, 0, 0);
    tbl[2] = mk(32'h80,    7, 32'h10,       0,  5, 0, 0, -1, -1, 0, 0, CHK, CHK ? 1 : 0);
    tbl[3] = mk(32'h0,     3, 32'h5,        0, -1, 0, 0, -1, -1, 1, 0, 1, 0);
    tbl[4] = mk(32'h200,   4, 32'hFFFFFFFE, 1, -1, 0, 0, -1, -1, 0, 0, 0, 0);
    tbl[5] = mk(32'h20,    2, 32'hABCD0000, 0, -1, 0, 2, -1, -1, 0, 0, 1, 0);
    tbl[6] = mk(32'h60,    3, 32'h77,       0, -1, 0, 0,  1, -1, 0, 0, 1, 0);
    tbl[7] = mk(32'h90,    5, 32'h1000,     0, -1, 0, 0, -1,  2, 0, 0, 1, 0);
    tbl[8] = mk(32'hC0,    6, 32'h2222,     1, -1, 0, 0, -1, -1, 0, 1, 0, 0);
    tbl[9] = mk(32'h0,   255, 32'd1234,     0, -1, 0, 0, -1, -1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    // random passes: expected ERROR/MISMATCH_CNT follow from which faults were injected
    for (int i = 0; i < 12; i++) begin
      v.len = $urandom_range(0, 20);
      v.base = 32'($urandom_range(0, 200)) * 4;
      v.seed = $urandom;
      v.stall = 1'b1;
      mode = $urandom_range(0, 2);
      v.corrupt = mode == 1 ? $urandom_range(0, v.len) : -1;
      v.corrupt_all = mode == 2;
      v.bresp = ($urandom % 5 == 0) ? 2'd2 : 2'd0;
      v.rerr = -1; v.rlast_at = -1; v.aw_block = 0; v.poke = 0;
      v.exp_mis = !CHK ? 0 : mode == 0 ? 0 : mode == 1 ? 1 : v.len + 1;
      v.exp_err = v.bresp != 2'd0 || v.exp_mis != 0;
      run_vec(v, $sformatf("rnd%0d", i));
    end
    // reset asserted in the middle of the write burst
    cfg_stall = 1; cfg_aw_block = 0; cfg_corrupt = -1; cfg_corrupt_all = 0;
    cfg_bresp = 0; cfg_rerr = -1; cfg_rlast_at = -1;
    cur_base = 32'h100; cur_seed = 32'h99; cur_len = 15;
    w_cnt = 0; r_cnt = 0; aw_cnt = 0;
    @(negedge ACLK);
    START = 1'b1; BASE_ADDR = cur_base; BURST_LEN = 8'd15; SEED = cur_seed;
    @(negedge ACLK);
    START = 1'b0;
    for (int i = 0; i < 500 && !(WVALID && w_cnt >= 2); i++) @(negedge ACLK);
    chk("reach_w", {WVALID, BUSY}, 2'b11);
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge ACLK);
      seen |= DONE | BUSY;
    end
    chk("no_done_after_rst", seen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
